// File: rtl/adler_pkg.sv
// Shared Adler-32 constants and the streaming engine's FSM encoding.
// No logic lives here; the engine and its lane step import it.
package adler_pkg;

    localparam logic [15:0] ADLER_MOD    = 16'd65521;
    localparam logic [15:0] ADLER_A_INIT = 16'd1;
    localparam logic [15:0] ADLER_B_INIT = 16'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } adler_state_t;

endpackage

// File: rtl/adler32_stream_lane_step.sv
// One Adler-32 byte step: A += d, B += A, each reduced by one conditional subtract.
// Purely combinational, no handshake; en=0 passes A/B through untouched.
module adler_lane_step
    import adler_pkg::*;
#(
    parameter logic [15:0] MOD = ADLER_MOD
) (
    input  logic [15:0] a_in,
    input  logic [15:0] b_in,
    input  logic [7:0]  din,
    input  logic        en,
    output logic [15:0] a_out,
    output logic [15:0] b_out
);

    localparam logic [16:0] MOD_W = {1'b0, MOD};

    logic [16:0] a_sum;
    logic [16:0] a_red;
    logic [16:0] b_sum;
    logic [16:0] b_red;

    always_comb begin
        a_sum = {1'b0, a_in} + {9'd0, din};
        a_red = (a_sum >= MOD_W) ? (a_sum - MOD_W) : a_sum;
        b_sum = {1'b0, b_in} + a_red;
        b_red = (b_sum >= MOD_W) ? (b_sum - MOD_W) : b_sum;
        a_out = en ? a_red[15:0] : a_in;
        b_out = en ? b_red[15:0] : b_in;
    end

endmodule

// File: rtl/adler32_stream.sv
// Streaming Adler-32 over LANES bytes per beat, with partial final beat and empty frames.
// Latency: checksum_valid pulses the cycle after the final transfer; data_ready only in RUN.
module adler32_stream
    import adler_pkg::*;
#(
    parameter int          LANES  = 4,
    parameter int          SIZE_W = 32,
    parameter logic [15:0] MOD    = ADLER_MOD
) (
    input  logic                 clock,
    input  logic                 rst_n,
    input  logic                 size_valid,
    input  logic [SIZE_W-1:0]    size,
    input  logic                 data_valid,
    input  logic [8*LANES-1:0]   data,
    output logic                 data_ready,
    output logic                 busy,
    output logic [31:0]          checksum,
    output logic                 checksum_valid
);

    adler_state_t        state;
    logic [15:0]         a_q;
    logic [15:0]         b_q;
    logic [SIZE_W-1:0]   remaining;
    logic [LANES-1:0]    lane_en;
    logic [LANES:0][15:0] a_ch;
    logic [LANES:0][15:0] b_ch;
    logic                xfer;
    logic                last_beat;

    assign data_ready = (state == ST_RUN);
    assign busy       = (state == ST_RUN);
    assign xfer       = data_valid && data_ready;
    assign last_beat  = (remaining <= SIZE_W'(LANES));

    // Only the first min(remaining, LANES) lanes take part in the chain.
    always_comb begin
        lane_en = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_en[k] = (remaining > SIZE_W'(k));
        end
    end

    assign a_ch[0] = a_q;
    assign b_ch[0] = b_q;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        adler_lane_step #(.MOD(MOD)) u_step (
            .a_in  (a_ch[k]),
            .b_in  (b_ch[k]),
            .din   (data[8*k +: 8]),
            .en    (lane_en[k]),
            .a_out (a_ch[k+1]),
            .b_out (b_ch[k+1])
        );
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            a_q            <= ADLER_A_INIT;
            b_q            <= ADLER_B_INIT;
            remaining      <= '0;
            checksum       <= {ADLER_B_INIT, ADLER_A_INIT};
            checksum_valid <= 1'b0;
        end else begin
            checksum_valid <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (size_valid) begin
                        a_q <= ADLER_A_INIT;
                        b_q <= ADLER_B_INIT;
                        if (size != '0) begin
                            state     <= ST_RUN;
                            remaining <= size;
                        end else begin
                            state          <= ST_DONE;
                            remaining      <= '0;
                            checksum       <= {ADLER_B_INIT, ADLER_A_INIT};
                            checksum_valid <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    // A new size_valid here is deliberately ignored until the frame ends.
                    if (xfer) begin
                        a_q <= a_ch[LANES];
                        b_q <= b_ch[LANES];
                        if (last_beat) begin
                            state          <= ST_DONE;
                            remaining      <= '0;
                            checksum       <= {b_ch[LANES], a_ch[LANES]};
                            checksum_valid <= 1'b1;
                        end else begin
                            remaining <= remaining - SIZE_W'(LANES);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
